// File: rtl/mem_loader.sv
// mem_loader: packs a host byte stream into 32-bit RAM words (LOAD) or streams RAM words back out as bytes (DUMP).
// Bytes are little-endian within a word; word addresses are base + index and wrap modulo 2^WIDTH.
module mem_loader #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_load,
    input  logic             start_dump,
    input  logic [WIDTH-1:0] base_addr,
    input  logic [WIDTH-1:0] word_count,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             mem_enw,
    output logic [WIDTH-1:0] mem_address,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             busy,
    output logic             done
);
    typedef enum logic [2:0] {IDLE, L_COLLECT, L_WRITE, D_READ, D_LATCH, D_SEND, FINISH} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] base_q, base_d, count_q, count_d, word_idx_q, word_idx_d, word_buf_q, word_buf_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [WIDTH-1:0] next_idx;

    assign next_idx = word_idx_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            count_q    <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            word_buf_q <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            word_buf_q <= word_buf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        word_buf_d = word_buf_q;
        case (state_q)
            IDLE: if (start_load || start_dump) begin
                base_d     = base_addr;
                count_d    = word_count;
                word_idx_d = '0;
                byte_idx_d = '0;
                state_d    = (word_count == '0) ? FINISH : start_load ? L_COLLECT : D_READ;
            end
            L_COLLECT: if (in_valid) begin
                word_buf_d[8*byte_idx_q +: 8] = in_data;
                byte_idx_d = byte_idx_q + 2'd1;
                if (byte_idx_q == 2'd3) state_d = L_WRITE;
            end
            L_WRITE: begin
                word_idx_d = next_idx;
                state_d    = (next_idx == count_q) ? FINISH : L_COLLECT;
            end
            D_READ:  state_d = D_LATCH;
            D_LATCH: begin
                word_buf_d = mem_rdata;
                byte_idx_d = '0;
                state_d    = D_SEND;
            end
            D_SEND: if (out_ready) begin
                byte_idx_d = byte_idx_q + 2'd1;
                if (byte_idx_q == 2'd3) begin
                    word_idx_d = next_idx;
                    state_d    = (next_idx == count_q) ? FINISH : D_READ;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready    = state_q == L_COLLECT;
        out_valid   = state_q == D_SEND;
        out_data    = (state_q == D_SEND) ? word_buf_q[8*byte_idx_q +: 8] : 8'h00;
        mem_enw     = state_q == L_WRITE;
        mem_wdata   = (state_q == L_WRITE) ? word_buf_q : '0;
        mem_address = base_q + word_idx_q;
        busy        = state_q != IDLE;
        done        = state_q == FINISH;
    end
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: directed-vector bench for mem_loader with a behavioural synchronous RAM.
module tb_mem_loader;
    logic        clk = 1'b0, rst = 1'b1;
    logic        start_load = 1'b0, start_dump = 1'b0;
    logic [31:0] base_addr = '0, word_count = '0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0, in_ready;
    logic [7:0]  out_data;
    logic        out_valid, out_ready = 1'b0;
    logic        mem_enw, busy, done;
    logic [31:0] mem_address, mem_wdata, mem_rdata = '0;

    int          checks = 0, errors = 0, done_cnt = 0;
    logic [31:0] wa[$], wd[$];
    logic [7:0]  got_bytes[$];
    logic [31:0] ram [logic [31:0]];

    mem_loader #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start_load(start_load), .start_dump(start_dump),
        .base_addr(base_addr), .word_count(word_count), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .mem_enw(mem_enw),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_rdata <= ram.exists(mem_address) ? ram[mem_address] : 32'h0;
        if (mem_enw) ram[mem_address] = mem_wdata;
    end

    always @(negedge clk) begin
        if (mem_enw) begin
            wa.push_back(mem_address);
            wd.push_back(mem_wdata);
        end
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic start(input logic ld, input logic dm, input logic [31:0] b, input logic [31:0] c);
        base_addr  = b;
        word_count = c;
        start_load = ld;
        start_dump = dm;
        @(negedge clk);
        start_load = 1'b0;
        start_dump = 1'b0;
    endtask

    task automatic load_byte(input logic [7:0] b);
        int t = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("in_ready_tmo", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("idle_tmo", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_enw", {31'd0, mem_enw}, 32'd0);
        check("rst_addr", mem_address, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
    endtask

    initial begin
        logic [7:0] exp_bytes[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        logic       hold;
        logic [7:0] held;
        int         t;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        @(negedge clk);

        // two-word load with continuous in_valid
        start(1'b1, 1'b0, 32'h10, 32'd2);
        check("ld_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 8; i++) load_byte(exp_bytes[i]);
        in_valid = 1'b0;
        check("ld_enw", {31'd0, mem_enw}, 32'd1);
        check("ld_addr", mem_address, 32'h11);
        check("ld_wdata", mem_wdata, 32'h88776655);
        @(negedge clk);
        check("ld_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        check("ld_busy_low", {31'd0, busy}, 32'd0);
        check("ld_done_low", {31'd0, done}, 32'd0);
        check("ld_nwr", wa.size(), 32'd2);
        check("ld_wa0", wa[0], 32'h10);
        check("ld_wd0", wd[0], 32'h44332211);
        check("ld_wa1", wa[1], 32'h11);
        check("ld_wd1", wd[1], 32'h88776655);
        check("ld_dones", done_cnt, 32'd1);

        // two-word dump with out_ready toggling
        start(1'b0, 1'b1, 32'h10, 32'd2);
        check("dp_busy", {31'd0, busy}, 32'd1);
        check("dp_nv0", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("dp_nv1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("dp_v", {31'd0, out_valid}, 32'd1);
        check("dp_first", {24'd0, out_data}, 32'h11);
        hold = 1'b0;
        held = '0;
        t = 0;
        while (busy && t < 200) begin
            if (hold) check("dp_hold", {24'd0, out_data}, {24'd0, held});
            out_ready = ~out_ready;
            if (out_valid && out_ready) got_bytes.push_back(out_data);
            hold = out_valid && !out_ready;
            held = out_data;
            @(negedge clk);
            t++;
        end
        out_ready = 1'b0;
        check("dp_tmo", {31'd0, busy}, 32'd0);
        check("dp_nbytes", got_bytes.size(), 32'd8);
        for (int i = 0; i < 8; i++) check($sformatf("dp_byte%0d", i), {24'd0, got_bytes[i]}, {24'd0, exp_bytes[i]});
        check("dp_nwr", wa.size(), 32'd2);
        check("dp_dones", done_cnt, 32'd2);

        // simultaneous starts: load wins; starts while busy ignored
        start(1'b1, 1'b1, 32'h20, 32'd1);
        check("both_in_ready", {31'd0, in_ready}, 32'd1);
        check("both_out_valid", {31'd0, out_valid}, 32'd0);
        start_dump = 1'b1;
        start_load = 1'b1;
        base_addr  = 32'h99;
        load_byte(8'h01);
        start_dump = 1'b0;
        start_load = 1'b0;
        load_byte(8'h02);
        load_byte(8'h03);
        load_byte(8'h04);
        in_valid = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        check("both_idle", {31'd0, busy}, 32'd0);
        check("both_nwr", wa.size(), 32'd3);
        check("both_wa", wa[2], 32'h20);
        check("both_wd", wd[2], 32'h04030201);
        check("both_nbytes", got_bytes.size(), 32'd8);
        check("both_dones", done_cnt, 32'd3);

        // zero word count
        in_valid = 1'b1;
        in_data  = 8'h5A;
        start(1'b1, 1'b0, 32'h50, 32'd0);
        check("z_done", {31'd0, done}, 32'd1);
        check("z_in_ready", {31'd0, in_ready}, 32'd0);
        check("z_enw", {31'd0, mem_enw}, 32'd0);
        @(negedge clk);
        check("z_busy", {31'd0, busy}, 32'd0);
        check("z_done_low", {31'd0, done}, 32'd0);
        in_valid = 1'b0;
        check("z_nwr", wa.size(), 32'd3);
        check("z_dones", done_cnt, 32'd4);

        // address wrap
        start(1'b1, 1'b0, 32'hFFFFFFFF, 32'd2);
        for (int i = 1; i <= 8; i++) load_byte(8'(i));
        in_valid = 1'b0;
        wait_idle();
        check("wr_nwr", wa.size(), 32'd5);
        check("wr_wa0", wa[3], 32'hFFFFFFFF);
        check("wr_wd0", wd[3], 32'h04030201);
        check("wr_wa1", wa[4], 32'h00000000);
        check("wr_wd1", wd[4], 32'h08070605);
        check("wr_dones", done_cnt, 32'd5);

        // reset in the middle of a load
        start(1'b1, 1'b0, 32'h30, 32'd1);
        load_byte(8'hEE);
        load_byte(8'hFF);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("mr_nwr", wa.size(), 32'd5);
        check("mr_dones", done_cnt, 32'd5);
        start(1'b1, 1'b0, 32'h40, 32'd1);
        load_byte(8'hA1);
        load_byte(8'hB2);
        load_byte(8'hC3);
        load_byte(8'hD4);
        in_valid = 1'b0;
        wait_idle();
        check("mr2_nwr", wa.size(), 32'd6);
        check("mr2_wa", wa[5], 32'h40);
        check("mr2_wd", wd[5], 32'hD4C3B2A1);
        check("mr2_dones", done_cnt, 32'd6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
